fixed_point_addsub_pipe: RTL and testbench

Pipelined sign-magnitude fixed-point add/subtract unit with runtime op select, selectable saturation or wrap on overflow, and valid/ready handshakes on both sides. It is the next-generation arithmetic core for the fixed-point datapath. It accepts one operation per cycle and delivers results in order with a fixed 2-cycle latency when not stalled.

---
 rtl/fixed_point_addsub_pipe.sv | 116 +++++++++++
 tb/tb_fixed_point_addsub_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage sign-magnitude fixed-point add/subtract unit with valid/ready handshakes.
// Stage 1 orders the magnitudes and picks the sign; stage 2 adds or subtracts and handles overflow.
module fixed_point_addsub_pipe #(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int M = N - 1;

  logic         s1_valid;
  logic         s1_eff_add;
  logic         s1_sign;
  logic [M-1:0] s1_big;
  logic [M-1:0] s1_small;

  logic         s2_load;
  logic         s1_load;

  logic         eff_b_sign;
  logic         eff_add;
  logic         a_larger;
  logic [M-1:0] mag_a;
  logic [M-1:0] mag_b;
  logic         pick_sign;
  logic [M-1:0] pick_big;
  logic [M-1:0] pick_small;

  logic [M:0]   sum;
  logic [M-1:0] result_mag;
  logic         result_ovf;
  logic         result_sign;

  // S2 is free when empty or draining; S1 may take a new pair when it is empty or moving on.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !rst && s1_load;

  assign mag_a      = a[M-1:0];
  assign mag_b      = b[M-1:0];
  assign eff_b_sign = b[N-1] ^ op;
  assign eff_add    = (a[N-1] == eff_b_sign);
  assign a_larger   = (mag_a >= mag_b);

  always_comb begin
    pick_big   = a_larger ? mag_a : mag_b;
    pick_small = a_larger ? mag_b : mag_a;
    if (eff_add || a_larger) begin
      pick_sign = a[N-1];
    end else begin
      pick_sign = eff_b_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_eff_add <= 1'b0;
      s1_sign    <= 1'b0;
      s1_big     <= '0;
      s1_small   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_eff_add <= eff_add;
        s1_sign    <= pick_sign;
        s1_big     <= pick_big;
        s1_small   <= pick_small;
      end
    end
  end

  // The subtract path never overflows because big >= small.
  always_comb begin
    sum        = {1'b0, s1_big} + {1'b0, s1_small};
    result_ovf = 1'b0;
    if (s1_eff_add) begin
      result_ovf = sum[M];
      if (sum[M] && SAT) begin
        result_mag = '1;
      end else begin
        result_mag = sum[M-1:0];
      end
    end else begin
      result_mag = s1_big - s1_small;
    end
    result_sign = (result_mag == '0) ? 1'b0 : s1_sign;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c   <= {result_sign, result_mag};
        ovf <= result_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Directed bench: two 8-bit instances (saturating and wrapping) share stimulus and are checked
// against hand-computed sign-magnitude results.
module tb_fixed_point_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       op;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] c;
  logic       ovf;

  logic       in_ready_w;
  logic       out_valid_w;
  logic [7:0] c_w;
  logic       ovf_w;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fixed_point_addsub_pipe #(.N(8), .Q(4), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf)
  );

  fixed_point_addsub_pipe #(.N(8), .Q(4), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .c(c_w), .ovf(ovf_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                                input logic iop);
    in_valid = v;
    a        = ia;
    b        = ib;
    op       = iop;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check_output("reset out_valid", {7'd0, out_valid}, 8'h00);
    check_output("reset c", c, 8'h00);
    check_output("reset ovf", {7'd0, ovf}, 8'h00);
    check_output("reset in_ready", {7'd0, in_ready}, 8'h00);
    rst = 1'b0;
    #1;
    check_output("in_ready after reset", {7'd0, in_ready}, 8'h01);

    // 5 - 3 with exact two-edge latency
    apply_stimulus(1'b1, 8'h05, 8'h03, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("latency not early", {7'd0, out_valid}, 8'h00);
    tick();
    check_output("5-3 valid", {7'd0, out_valid}, 8'h01);
    check_output("5-3 c", c, 8'h02);
    check_output("5-3 ovf", {7'd0, ovf}, 8'h00);
    check_output("5-3 wrap c", c_w, 8'h02);
    tick();
    check_output("drained", {7'd0, out_valid}, 8'h00);

    // 3 + (-5) = -2, then (-5) - 3 = -8, back to back
    apply_stimulus(1'b1, 8'h03, 8'h85, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'h85, 8'h03, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("3+-5 c", c, 8'h82);
    tick();
    check_output("-5-3 valid", {7'd0, out_valid}, 8'h01);
    check_output("-5-3 c", c, 8'h88);
    check_output("-5-3 ovf", {7'd0, ovf}, 8'h00);

    // Overflow: saturate vs wrap; then the largest sum that still fits
    apply_stimulus(1'b1, 8'h7F, 8'h01, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'h7E, 8'h01, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("sat c", c, 8'h7F);
    check_output("sat ovf", {7'd0, ovf}, 8'h01);
    check_output("wrap c", c_w, 8'h00);
    check_output("wrap ovf", {7'd0, ovf_w}, 8'h01);
    tick();
    check_output("7E+1 c", c, 8'h7F);
    check_output("7E+1 ovf", {7'd0, ovf}, 8'h00);
    check_output("7E+1 wrap c", c_w, 8'h7F);

    // Zero normalisation
    apply_stimulus(1'b1, 8'h85, 8'h85, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'h80, 8'h80, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("-5--5 c", c, 8'h00);
    tick();
    check_output("-0+-0 valid", {7'd0, out_valid}, 8'h01);
    check_output("-0+-0 c", c, 8'h00);
    tick();

    // Stall with out_ready low: only two transfers fit
    out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h01, 8'h01, 1'b0);
    check_output("stall in_ready 0", {7'd0, in_ready}, 8'h01);
    tick();
    apply_stimulus(1'b1, 8'h02, 8'h01, 1'b0);
    check_output("stall in_ready 1", {7'd0, in_ready}, 8'h01);
    tick();
    apply_stimulus(1'b1, 8'h03, 8'h01, 1'b0);
    check_output("stall in_ready 2", {7'd0, in_ready}, 8'h00);
    check_output("stall c first", c, 8'h02);
    tick();
    check_output("stall c hold", c, 8'h02);
    check_output("stall ovf hold", {7'd0, ovf}, 8'h00);
    check_output("stall valid hold", {7'd0, out_valid}, 8'h01);
    tick();
    check_output("stall c hold 2", c, 8'h02);
    out_ready = 1'b1;
    #1;
    check_output("release in_ready", {7'd0, in_ready}, 8'h01);
    tick();
    apply_stimulus(1'b1, 8'h04, 8'h01, 1'b0);
    check_output("release r1", c, 8'h03);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("release r2", c, 8'h04);
    tick();
    check_output("release r3", c, 8'h05);
    check_output("release r3 valid", {7'd0, out_valid}, 8'h01);
    tick();
    check_output("release empty", {7'd0, out_valid}, 8'h00);

    // Sustained throughput: one result per cycle
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        apply_stimulus(1'b1, 8'h10 + 8'(i), 8'h01, 1'b0);
        check_output("burst in_ready", {7'd0, in_ready}, 8'h01);
      end else begin
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
      end
      tick();
      if (i >= 1) begin
        check_output("burst valid", {7'd0, out_valid}, 8'h01);
        check_output("burst c", c, 8'h10 + 8'(i));
      end
    end
    tick();
    check_output("burst empty", {7'd0, out_valid}, 8'h00);

    // Reset with both stages full
    out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h7F, 8'h7F, 1'b0);
    tick();
    apply_stimulus(1'b1, 8'h20, 8'h01, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("pre-reset ovf", {7'd0, ovf}, 8'h01);
    rst = 1'b1;
    #1;
    check_output("rst in_ready", {7'd0, in_ready}, 8'h00);
    tick();
    check_output("mid rst valid", {7'd0, out_valid}, 8'h00);
    check_output("mid rst c", c, 8'h00);
    check_output("mid rst ovf", {7'd0, ovf}, 8'h00);
    rst       = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b1, 8'h0A, 8'h05, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
    check_output("post rst no stale", {7'd0, out_valid}, 8'h00);
    tick();
    check_output("post rst valid", {7'd0, out_valid}, 8'h01);
    check_output("post rst c", c, 8'h05);
    tick();
    check_output("post rst drained", {7'd0, out_valid}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
